// File: rtl/ds_dac_pkg.sv
// Shared types and constants for the delta-sigma DAC host register front end.
package ds_dac_pkg;

    typedef enum logic [1:0] {
        SLOT_SAMPLE = 2'd0,
        SLOT_CTRL   = 2'd1,
        SLOT_MODE   = 2'd2,
        SLOT_CMD    = 2'd3
    } slot_e;

    localparam int CMD_CLR   = 0;
    localparam int CMD_FLUSH = 1;
    localparam int CMD_LFSR  = 2;

    localparam logic [15:0] SAMPLE_RESET = 16'h8000;

    localparam int STAT_OVF     = 7;
    localparam int STAT_UNF     = 6;
    localparam int STAT_LVL_LSB = 0;

    typedef struct packed {
        logic       overflow;
        logic       underrun;
        logic [1:0] rsvd;
        logic [3:0] level;
    } status_t;

    // Level is reported in four bits; deeper FIFOs pin at 15.
    function automatic logic [3:0] sat_level(input logic [31:0] lvl);
        return (lvl > 32'd15) ? 4'hF : lvl[3:0];
    endfunction

endpackage

// File: rtl/ds_sample_fifo.sv
// Per-channel sample FIFO with flush, sticky overflow/underrun flags and
// the registered sample output consumed by one modulator.
module ds_sample_fifo
    import ds_dac_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [15:0]              push_data,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     clear,
    output logic [15:0]              sample,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [15:0]   mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_addr;
    logic [LW-1:0] level_reg, level_next;
    logic          ovf_reg, ovf_next;
    logic          unf_reg, unf_next;
    logic [15:0]   sample_reg;
    logic          full, empty;
    logic          do_push, do_pop, ovf_set, unf_set;

    always_comb begin
        full        = (level_reg == LW'(DEPTH));
        empty       = (level_reg == '0);
        do_push     = 1'b0;
        do_pop      = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        wr_addr     = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        level_next  = level_reg;
        if (flush) begin
            // Flush empties first; a concurrent push lands in the emptied FIFO.
            do_push     = push;
            wr_addr     = '0;
            rd_ptr_next = '0;
            wr_ptr_next = push ? PW'(1) : '0;
            level_next  = push ? LW'(1) : '0;
        end else begin
            do_pop      = pop & ~empty;
            unf_set     = pop & empty;
            do_push     = push & (~full | do_pop);
            ovf_set     = push & full & ~do_pop;
            rd_ptr_next = rd_ptr_reg + PW'(do_pop);
            wr_ptr_next = wr_ptr_reg + PW'(do_push);
            level_next  = level_reg + LW'(do_push) - LW'(do_pop);
        end
        ovf_next = ovf_set | (ovf_reg & ~clear);
        unf_next = unf_set | (unf_reg & ~clear);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            ovf_reg    <= ovf_next;
            unf_reg    <= unf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_addr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_reg <= SAMPLE_RESET;
        end else if (do_pop) begin
            sample_reg <= mem_reg[rd_ptr_reg];
        end
    end

    assign sample   = sample_reg;
    assign level    = level_reg;
    assign overflow = ovf_reg;
    assign underrun = unf_reg;

endmodule

// File: rtl/ds_dac_host_regs.sv
// Byte-serial host register front end for NUM_CH delta-sigma modulators.
// Define DS_DAC_HOST_BROADCAST_EN to let the all-ones channel code write every channel.
module ds_dac_host_regs
    import ds_dac_pkg::*;
#(
    parameter int          NUM_CH      = 2,
    parameter int          ADDR_BITS   = 4,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] CTRL_RESET  = 16'h0700
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             data_in,
    input  logic [ADDR_BITS-1:0]   addr_in,
    input  logic                   data_part_in,
    input  logic [NUM_CH-1:0]      sample_req,
    output logic [16*NUM_CH-1:0]   sample_out,
    output logic [16*NUM_CH-1:0]   ctrl_out,
    output logic [16*NUM_CH-1:0]   mode_out,
    output logic [NUM_CH-1:0]      lfsr_reset,
    output logic [NUM_CH-1:0]      pulse_toggle,
    output logic [7:0]             status_out
);

    localparam int CH_W  = ADDR_BITS - 2;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES:0] sync_reg;
    logic [7:0]           data_low_reg;
    logic                 dp, dp_last;
    logic                 wr_stb;
    logic [15:0]          word;
    logic [CH_W-1:0]      wr_ch;
    slot_e                wr_slot;
    logic                 is_bcast;
    logic [CH_W-1:0]      stat_ch;

    logic [LVL_W-1:0]     level_w [NUM_CH];
    logic [NUM_CH-1:0]    ovf_w;
    logic [NUM_CH-1:0]    unf_w;

    // Loaded with ones so leaving reset with the strobe high never looks like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-1:0], data_part_in};
        end
    end

    assign dp      = sync_reg[SYNC_STAGES-1];
    assign dp_last = sync_reg[SYNC_STAGES];
    assign wr_stb  = dp & ~dp_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_low_reg <= 8'h00;
        end else if (~dp & dp_last) begin
            data_low_reg <= data_in;
        end
    end

    assign word    = {data_in, data_low_reg};
    assign wr_ch   = addr_in[ADDR_BITS-1:2];
    assign wr_slot = slot_e'(addr_in[1:0]);

`ifdef DS_DAC_HOST_BROADCAST_EN
    localparam logic [CH_W-1:0] CH_BCAST = '1;
    assign is_bcast = (wr_ch == CH_BCAST);
    assign stat_ch  = is_bcast ? '0 : wr_ch;
`else
    assign is_bcast = 1'b0;
    assign stat_ch  = wr_ch;
`endif

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic        hit;
            logic        cmd_hit;
            logic [15:0] ctrl_reg;
            logic [15:0] mode_reg;
            logic        lfsr_reg;
            logic        toggle_reg;

            assign hit     = wr_stb & ((wr_ch == CH_W'(gi)) | is_bcast);
            assign cmd_hit = hit & (wr_slot == SLOT_CMD);

            ds_sample_fifo #(
                .DEPTH(FIFO_DEPTH)
            ) u_fifo (
                .clk      (clk),
                .reset    (reset),
                .push     (hit & (wr_slot == SLOT_SAMPLE)),
                .push_data(word),
                .pop      (sample_req[gi]),
                .flush    (cmd_hit & word[CMD_FLUSH]),
                .clear    (cmd_hit & word[CMD_CLR]),
                .sample   (sample_out[16*gi +: 16]),
                .level    (level_w[gi]),
                .overflow (ovf_w[gi]),
                .underrun (unf_w[gi])
            );

            always_ff @(posedge clk) begin
                if (reset) begin
                    ctrl_reg   <= CTRL_RESET;
                    mode_reg   <= 16'h0000;
                    lfsr_reg   <= 1'b0;
                    toggle_reg <= 1'b0;
                end else begin
                    if (hit && wr_slot == SLOT_CTRL) begin
                        ctrl_reg <= word;
                    end
                    if (hit && wr_slot == SLOT_MODE) begin
                        mode_reg <= word;
                    end
                    lfsr_reg   <= cmd_hit & word[CMD_LFSR];
                    toggle_reg <= toggle_reg ^ sample_req[gi];
                end
            end

            assign ctrl_out[16*gi +: 16] = ctrl_reg;
            assign mode_out[16*gi +: 16] = mode_reg;
            assign lfsr_reset[gi]        = lfsr_reg;
            assign pulse_toggle[gi]      = toggle_reg;
        end
    endgenerate

    // Unmatched channel codes fall through to an all-zero status byte.
    always_comb begin
        status_t st;
        st = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (stat_ch == CH_W'(i)) begin
                st.overflow = ovf_w[i];
                st.underrun = unf_w[i];
                st.level    = sat_level(32'(level_w[i]));
            end
        end
        status_out = st;
    end

endmodule
